// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 width encodings, FSM state enum and access-legality helper for the load/store unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // illegal width code (011/110/111) or an address not aligned to the access size
    function automatic logic lsu_bad_access(input logic [2:0] f3, input logic [1:0] off);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) ||
               ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3 == F3_W) && (off != 2'b00));
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for stores and lane select plus sign/zero extension for loads
//   funct3_i  width code, off_i byte offset within the word
//   wdata_i   right-aligned store data  -> wdata_o replicated across lanes, be_o byte enables
//   rdata_i   bus read word             -> rdata_o selected and extended load value
module lsu_align
    import lsu_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         off_i,
    input  logic [BITSIZE-1:0] wdata_i,
    input  logic [BITSIZE-1:0] rdata_i,
    output logic [3:0]         be_o,
    output logic [BITSIZE-1:0] wdata_o,
    output logic [BITSIZE-1:0] rdata_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // funct3[2] marks the unsigned variants; funct3[1:0] gives the size
    always_comb begin
        be_o     = (funct3_i[1:0] == 2'b00) ? 4'b0001 << off_i :
                   (funct3_i[1:0] == 2'b01) ? 4'b0011 << off_i : 4'b1111;
        wdata_o  = (funct3_i[1:0] == 2'b00) ? {4{wdata_i[7:0]}} :
                   (funct3_i[1:0] == 2'b01) ? {2{wdata_i[15:0]}} : wdata_i;
        byte_sel = (off_i == 2'd0) ? rdata_i[7:0]   :
                   (off_i == 2'd1) ? rdata_i[15:8]  :
                   (off_i == 2'd2) ? rdata_i[23:16] : rdata_i[31:24];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        rdata_o  = (funct3_i[1:0] == 2'b00) ? {{24{~funct3_i[2] & byte_sel[7]}}, byte_sel} :
                   (funct3_i[1:0] == 2'b01) ? {{16{~funct3_i[2] & half_sel[15]}}, half_sel} : rdata_i;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store stage between execute and writeback with a simple req/ack bus
//   clk, rstn_i                       clock, async active-low reset
//   valid_i/ready_o + op fields       operation from execute (mem_en_i, we_i, funct3_i, addr_i, wdata_i, rd_i)
//   valid_o/ready_i + result fields   result to writeback (rd_o, result_o, err_o)
//   mem_*                             word-aligned bus request with byte enables, completed by mem_ack_i
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               mem_en_i,
    input  logic               we_i,
    input  logic [2:0]         funct3_i,
    input  logic [BITSIZE-1:0] addr_i,
    input  logic [BITSIZE-1:0] wdata_i,
    input  logic [4:0]         rd_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [4:0]         rd_o,
    output logic [BITSIZE-1:0] result_o,
    output logic               err_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    output logic [BITSIZE-1:0] mem_wdata_o,
    output logic [3:0]         mem_be_o,
    input  logic               mem_ack_i,
    input  logic [BITSIZE-1:0] mem_rdata_i
);
    lsu_state_e         state_q, state_d;
    logic               we_q, we_d, err_q, err_d, bad;
    logic [2:0]         f3_q, f3_d;
    logic [4:0]         rd_q, rd_d;
    logic [BITSIZE-1:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
    logic [3:0]         be;
    logic [BITSIZE-1:0] wdata_steer, load_data;

    lsu_align #(.BITSIZE(BITSIZE)) u_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata_i),
        .be_o     (be),
        .wdata_o  (wdata_steer),
        .rdata_o  (load_data)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        err_d    = err_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        bad      = mem_en_i && lsu_bad_access(funct3_i, addr_i[1:0]);
        case (state_q)
            ST_IDLE: if (valid_i) begin
                we_d     = mem_en_i & we_i;
                err_d    = bad;
                f3_d     = funct3_i;
                addr_d   = addr_i;
                wdata_d  = wdata_i;
                rd_d     = (bad || (mem_en_i && we_i)) ? 5'd0 : rd_i;
                result_d = addr_i;
                state_d  = (!mem_en_i || bad) ? ST_DONE : ST_BUS;
            end
            ST_BUS: if (mem_ack_i) begin
                result_d = we_q ? result_q : load_data;
                state_d  = ST_DONE;
            end
            ST_DONE: if (ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            f3_q     <= 3'b000;
            rd_q     <= 5'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            err_q    <= err_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
        end
    end

    // bus outputs are forced to zero outside BUS so reset and idle look identical on the bus
    assign ready_o     = (state_q == ST_IDLE);
    assign valid_o     = (state_q == ST_DONE);
    assign mem_req_o   = (state_q == ST_BUS);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_addr_o  = mem_req_o ? {addr_q[BITSIZE-1:2], 2'b00} : '0;
    assign mem_be_o    = mem_req_o ? be : 4'b0000;
    assign mem_wdata_o = mem_req_o ? wdata_steer : '0;
    assign err_o       = valid_o & err_q;
    assign rd_o        = rd_q;
    assign result_o    = result_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        valid_i = 1'b0, mem_en_i = 1'b0, we_i = 1'b0, ready_i = 1'b1, mem_ack_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = '0, wdata_i = '0, mem_rdata_i = '0;
    logic [4:0]  rd_i = '0;
    logic        ready_o, valid_o, err_o, mem_req_o, mem_we_o;
    logic [4:0]  rd_o;
    logic [31:0] result_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    int checks = 0;
    int failures = 0;

    load_store_unit #(.BITSIZE(32)) dut (
        .clk(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
        .mem_en_i(mem_en_i), .we_i(we_i), .funct3_i(funct3_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rd_i(rd_i), .valid_o(valid_o), .ready_i(ready_i),
        .rd_o(rd_o), .result_o(result_o), .err_o(err_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // present an operation for one cycle; returns on the negedge after acceptance
    task automatic op(input logic en, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        valid_i = 1'b1; mem_en_i = en; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; rd_i = rd;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rdata);
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
        @(negedge clk);
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    endtask

    initial begin
        #2;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_be", mem_be_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_rd", rd_o, 0);
        @(negedge clk); @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);

        // pass-through
        op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        chk("pt_valid", valid_o, 1);
        chk("pt_result", result_o, 32'h1234);
        chk("pt_rd", rd_o, 5);
        chk("pt_req", mem_req_o, 0);
        chk("pt_ready", ready_o, 0);
        @(negedge clk);
        chk("pt_idle", ready_o, 1);
        chk("pt_valid_low", valid_o, 0);

        // ack in IDLE is ignored
        ack(32'h1111_2222);
        chk("idle_ack_valid", valid_o, 0);
        chk("idle_ack_ready", ready_o, 1);

        // LB at 0x103, ack three cycles after request
        op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
        chk("lb_req", mem_req_o, 1);
        chk("lb_addr", mem_addr_o, 32'h100);
        chk("lb_be", mem_be_o, 4'b1000);
        chk("lb_we", mem_we_o, 0);
        chk("lb_ready", ready_o, 0);
        @(negedge clk);
        chk("lb_req_hold1", mem_req_o, 1);
        @(negedge clk);
        chk("lb_req_hold2", mem_req_o, 1);
        chk("lb_addr_hold", mem_addr_o, 32'h100);
        ack(32'h80AA_BBCC);
        chk("lb_valid", valid_o, 1);
        chk("lb_result", result_o, 32'hFFFF_FF80);
        chk("lb_rd", rd_o, 7);
        chk("lb_err", err_o, 0);
        chk("lb_req_done", mem_req_o, 0);
        @(negedge clk);

        // LHU at 0x302: upper half, zero extended
        op(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0, 5'd8);
        chk("lhu_be", mem_be_o, 4'b1100);
        ack(32'h8001_7FFF);
        chk("lhu_result", result_o, 32'h0000_8001);
        @(negedge clk);

        // LH at 0x300: lower half, sign extended
        op(1'b1, 1'b0, 3'b001, 32'h0000_0300, 32'h0, 5'd8);
        chk("lh_be", mem_be_o, 4'b0011);
        ack(32'h1234_8765);
        chk("lh_result", result_o, 32'hFFFF_8765);
        @(negedge clk);

        // SH at 0x202
        op(1'b1, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd9);
        chk("sh_we", mem_we_o, 1);
        chk("sh_be", mem_be_o, 4'b1100);
        chk("sh_wdata", mem_wdata_o, 32'hBEEF_BEEF);
        chk("sh_addr", mem_addr_o, 32'h200);
        ack(32'h0);
        chk("sh_valid", valid_o, 1);
        chk("sh_rd", rd_o, 0);
        chk("sh_err", err_o, 0);
        @(negedge clk);

        // SB at 0x001
        op(1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 5'd4);
        chk("sb_be", mem_be_o, 4'b0010);
        chk("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        ack(32'h0);
        @(negedge clk);

        // misaligned LW at 0x101
        op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3);
        chk("mis_req", mem_req_o, 0);
        chk("mis_valid", valid_o, 1);
        chk("mis_err", err_o, 1);
        chk("mis_rd", rd_o, 0);
        @(negedge clk);

        // illegal funct3 011
        op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd3);
        chk("ill_req", mem_req_o, 0);
        chk("ill_err", err_o, 1);
        @(negedge clk);
        chk("ill_err_clear", err_o, 0);

        // backpressure on an LW result
        ready_i = 1'b0;
        op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd12);
        chk("bp_be", mem_be_o, 4'b1111);
        ack(32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", valid_o, 1);
            chk("bp_result", result_o, 32'hDEAD_BEEF);
            chk("bp_rd", rd_o, 12);
            chk("bp_ready", ready_o, 0);
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release", ready_o, 1);
        chk("bp_valid_low", valid_o, 0);

        // reset while in BUS, then a late ack
        op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd6);
        chk("rb_req", mem_req_o, 1);
        rstn_i = 1'b0;
        #1;
        chk("rb_req_drop", mem_req_o, 0);
        chk("rb_ready", ready_o, 1);
        chk("rb_addr", mem_addr_o, 0);
        chk("rb_be", mem_be_o, 0);
        @(negedge clk);
        rstn_i = 1'b1;
        ack(32'hCAFE_F00D);
        chk("rb_valid", valid_o, 0);
        chk("rb_req_after", mem_req_o, 0);
        @(negedge clk);
        chk("rb_valid2", valid_o, 0);
        chk("rb_ready2", ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter BITSIZE, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rstn_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_i  input  1  execute stage presents an operation.
REQ-005 SHALL have port ready_o  output  1  unit can accept an operation.
REQ-006 SHALL have port mem_en_i  input  1  1 = load/store; 0 = pass ALU result through.
REQ-007 SHALL have port we_i  input  1  1 = store, 0 = load (valid when mem_en_i=1).
REQ-008 SHALL have port funct3_i  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port addr_i  input  BITSIZE  ALU result; it is the byte address for memory ops.
REQ-010 SHALL have port wdata_i  input  BITSIZE  store data (rs2), right-aligned.
REQ-011 SHALL have port rd_i  input  5  destination register.
REQ-012 SHALL have port valid_o  output  1  result available to writeback.
REQ-013 SHALL have port ready_i  input  1  writeback accepts the result.
REQ-014 SHALL have port rd_o  output  5  destination register; 0 for stores and errors.
REQ-015 SHALL have port result_o  output  BITSIZE  load data (extended) or pass-through ALU result.
REQ-016 SHALL have port err_o  output  1  misaligned or illegal funct3; qualified by valid_o.
REQ-017 SHALL have port mem_req_o  output  1  bus request.
REQ-018 SHALL have port mem_we_o  output  1  bus write enable.
REQ-019 SHALL have port mem_addr_o  output  BITSIZE  word-aligned address ([1:0]=00).
REQ-020 SHALL have port mem_wdata_o  output  BITSIZE  lane-steered store data.
REQ-021 SHALL have port mem_be_o  output  4  byte enables.
REQ-022 SHALL have port mem_ack_i  input  1  bus completion; single-cycle pulse.
REQ-023 SHALL have port mem_rdata_i  input  BITSIZE  read word, valid with mem_ack_i.

Function
REQ-024 SHALL implement FSM IDLE -> BUS -> DONE -> IDLE; ready_o=1 only in IDLE (no skid buffer).
REQ-025 SHALL, in IDLE when valid_i=1, register all inputs; enter DONE if mem_en_i=0 or on error, else enter BUS.
REQ-026 SHALL flag an error for funct3 in {011,110,111}, H/HU with addr[0]=1, or W with addr[1:0]!=00; no bus request is issued; err_o=1 in DONE.
REQ-027 SHALL, in BUS, hold mem_req_o=1 and all mem_* outputs stable until mem_ack_i=1, then enter DONE on the next edge.
REQ-028 SHALL drive mem_be_o as follows: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
REQ-029 SHALL drive mem_wdata_o as the byte/half replicated across all lanes.
REQ-030 SHALL, on a load ack, register result_o as the selected lane: sign-extended for B/H, zero-extended for BU/HU, full word for W.
REQ-031 SHALL, on a store ack, leave result_o as don't-care and force rd_o=0.
REQ-032 SHALL, in DONE, hold valid_o=1 and the outputs stable until ready_i=1, then return to IDLE. A new input is accepted no earlier than the following cycle.
REQ-033 SHALL meet these latencies: pass-through accepted in cycle N gives valid_o in N+1. Memory op gives mem_req_o in N+1; ack in cycle M gives valid_o in M+1.
REQ-034 SHALL ignore mem_ack_i outside BUS.
REQ-035 SHALL set mem_req_o=0 in IDLE and DONE.

Reset
REQ-036 SHALL, while rstn_i=0, immediately force IDLE, ready_o=1, valid_o=0, mem_req_o=0, mem_we_o=0, err_o=0, and all data outputs and mem_be_o to 0.
REQ-037 SHALL abandon any operation in flight when reset asserts, including in BUS; a late ack after reset is ignored.

Structure
REQ-038 SHALL take the funct3 encodings and the state enum from shared package lsu_pkg.
REQ-039 SHALL place byte-lane steering and extension in combinational sub-module lsu_align.

Verification
REQ-040 Pass-through: mem_en_i=0, addr_i=0x0000_1234, rd_i=5, ready_i=1 -> next cycle valid_o=1, result_o=0x1234, rd_o=5, mem_req_o never asserted.
REQ-041 LB: addr_i=0x103, mem_rdata_i=0x80AA_BBCC, ack 3 cycles after req -> mem_addr_o=0x100, mem_be_o=1000, result_o=0xFFFF_FF80.
REQ-042 SH: addr_i=0x202, wdata_i=0x0000_BEEF -> mem_we_o=1, mem_be_o=1100, mem_wdata_o=0xBEEF_BEEF, rd_o=0 on valid_o.
REQ-043 Misaligned LW at 0x101 -> no mem_req_o; valid_o=1 with err_o=1 and rd_o=0 the next cycle.
REQ-044 Backpressure: ready_i=0 for 4 cycles in DONE -> valid_o, result_o and rd_o stable and ready_o=0 throughout.
REQ-045 Reset in BUS: rstn_i=0 while mem_req_o=1 -> mem_req_o=0 at once; an ack after release is ignored and valid_o stays 0.
